dispatch_alloc: RTL and testbench

//  Parametrised N-wide dispatch stage between rename and the ROB/reservation station.

---
 rtl/dispatch_alloc_pkg.sv | 51 +++++
 rtl/dispatch_if.sv | 12 +
 rtl/dispatch_rob_idx.sv | 28 ++
 rtl/dispatch_alloc.sv | 124 ++++++++++++
 tb/tb_dispatch_alloc.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dispatch_alloc_pkg.sv
// Shared types and constants for the dispatch/allocation stage.
// Struct field widths come from the DA_* constants below.
package dispatch_alloc_pkg;

  localparam int DA_ROB_DEPTH = 16;
  localparam int DA_ROB_IDX_W = $clog2(DA_ROB_DEPTH);
  localparam int DA_NUM_ALU   = 2;
  localparam int DA_FU_W      = $clog2(DA_NUM_ALU + 1);
  localparam int PREG_W       = 6;
  localparam int ALU_OP_W     = 4;
  localparam int IMM_W        = 16;

  // The memory FU sits just above the last ALU index.
  localparam logic [DA_FU_W-1:0] FU_MEM = DA_FU_W'(DA_NUM_ALU);

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                mem_read;
    logic                mem_write;
    logic [PREG_W-1:0]   preg_src0;
    logic [PREG_W-1:0]   preg_src1;
    logic [PREG_W-1:0]   preg_dst;
    logic [PREG_W-1:0]   old_preg_dst;
    logic [IMM_W-1:0]    imm;
  } rename_struct;

  typedef struct packed {
    logic              valid;
    logic              complete;
    logic [PREG_W-1:0] preg_dst;
    logic [PREG_W-1:0] old_preg_dst;
  } rob_row_struct;

  typedef struct packed {
    logic                    in_use;
    logic [ALU_OP_W-1:0]     alu_op;
    logic [PREG_W-1:0]       preg_src0;
    logic [PREG_W-1:0]       preg_src1;
    logic [PREG_W-1:0]       preg_dst;
    logic [IMM_W-1:0]        imm;
    logic                    src0_ready;
    logic                    src1_ready;
    logic [DA_ROB_IDX_W-1:0] rob_num;
    logic [DA_FU_W-1:0]      fu;
  } rs_row_struct;

  function automatic logic is_mem_op(input rename_struct op);
    return op.mem_read | op.mem_write;
  endfunction

endpackage

// File: rtl/dispatch_if.sv
// Rename-to-dispatch bundle handshake.
interface dispatch_if #(parameter int WIDTH = 2);
  import dispatch_alloc_pkg::*;

  logic                     valid;
  logic [WIDTH-1:0]         lane_mask;
  rename_struct [WIDTH-1:0] rename_data;
  logic                     ready;

  modport master (output valid, lane_mask, rename_data, input ready);
  modport slave  (input valid, lane_mask, rename_data, output ready);
endinterface

// File: rtl/dispatch_rob_idx.sv
// Prefix-popcount ROB-number generator: lane i gets tail plus the number of
// present lanes below it; ROB depth is a power of two so wrap is truncation.
module dispatch_rob_idx #(
  parameter  int WIDTH     = 2,
  parameter  int ROB_IDX_W = 4,
  localparam int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic [ROB_IDX_W-1:0]            tail,
  input  logic [WIDTH-1:0]                lane_mask,
  output logic [WIDTH-1:0][ROB_IDX_W-1:0] rob_num,
  output logic [CNT_W-1:0]                count,
  output logic [ROB_IDX_W-1:0]            next_tail
);

  logic [CNT_W-1:0] acc;

  always_comb begin
    acc     = '0;
    rob_num = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rob_num[i] = tail + ROB_IDX_W'(acc);
      acc        = acc + CNT_W'(lane_mask[i]);
    end
    count     = acc;
    next_tail = tail + ROB_IDX_W'(acc);
  end

endmodule

// File: rtl/dispatch_alloc.sv
// N-wide dispatch stage: capacity check, ROB numbering, FU steering, registered ROB/RS rows.
// Optional DISPATCH_ALLOC_STATS_EN adds a saturating stall-cycle counter o_stall_cnt.
module dispatch_alloc
  import dispatch_alloc_pkg::*;
#(
  parameter  int WIDTH     = 2,
  parameter  int ROB_DEPTH = DA_ROB_DEPTH,
  parameter  int RS_DEPTH  = 8,
  parameter  int NUM_ALU   = DA_NUM_ALU,
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH),
  localparam int RS_CNT_W  = $clog2(RS_DEPTH + 1),
  localparam int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  dispatch_if.slave                 ren,
  input  logic [ROB_IDX_W:0]        i_rob_free,
  input  logic [RS_CNT_W-1:0]       i_rs_free,
  input  logic                      i_flush,
  input  logic [ROB_IDX_W-1:0]      i_flush_tail,
  output logic [WIDTH-1:0]          o_rob_we,
  output rob_row_struct [WIDTH-1:0] o_rob_rows,
  output logic [WIDTH-1:0]          o_rs_we,
  output rs_row_struct [WIDTH-1:0]  o_rs_rows,
  output logic [ROB_IDX_W-1:0]      o_tail
`ifdef DISPATCH_ALLOC_STATS_EN
  ,
  output logic [31:0]               o_stall_cnt
`endif
);

  logic [WIDTH-1:0][ROB_IDX_W-1:0] rob_num;
  logic [CNT_W-1:0]                n_ops;
  logic [ROB_IDX_W-1:0]            next_tail;
  logic                            rdy;
  logic                            accept;
  logic [DA_FU_W-1:0]              alu_ptr;
  logic [DA_FU_W-1:0]              alu_ptr_nxt;
  logic [DA_FU_W-1:0]              ptr;
  rename_struct                    op;
  rob_row_struct [WIDTH-1:0]       rob_nxt;
  rs_row_struct  [WIDTH-1:0]       rs_nxt;

  dispatch_rob_idx #(
    .WIDTH     (WIDTH),
    .ROB_IDX_W (ROB_IDX_W)
  ) u_rob_idx (
    .tail      (o_tail),
    .lane_mask (ren.lane_mask),
    .rob_num   (rob_num),
    .count     (n_ops),
    .next_tail (next_tail)
  );

  assign rdy       = !i_flush && (32'(i_rob_free) >= 32'(n_ops)) && (32'(i_rs_free) >= 32'(n_ops));
  assign ren.ready = rdy;
  assign accept    = ren.valid && rdy && (n_ops != '0);

  // Round-robin ALU pointer walks non-memory ops in lane order.
  always_comb begin
    ptr     = alu_ptr;
    op      = '0;
    rob_nxt = '0;
    rs_nxt  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      op                      = ren.rename_data[i];
      rob_nxt[i].valid        = 1'b1;
      rob_nxt[i].complete     = 1'b0;
      rob_nxt[i].preg_dst     = op.preg_dst;
      rob_nxt[i].old_preg_dst = op.old_preg_dst;
      rs_nxt[i].in_use        = 1'b1;
      rs_nxt[i].alu_op        = op.alu_op;
      rs_nxt[i].preg_src0     = op.preg_src0;
      rs_nxt[i].preg_src1     = op.preg_src1;
      rs_nxt[i].preg_dst      = op.preg_dst;
      rs_nxt[i].imm           = op.imm;
      rs_nxt[i].src0_ready    = 1'b0;
      rs_nxt[i].src1_ready    = 1'b0;
      rs_nxt[i].rob_num       = rob_num[i];
      rs_nxt[i].fu            = FU_MEM;
      if (ren.lane_mask[i] && !is_mem_op(op)) begin
        rs_nxt[i].fu = ptr;
        ptr = (ptr == DA_FU_W'(NUM_ALU - 1)) ? '0 : ptr + DA_FU_W'(1);
      end
    end
    alu_ptr_nxt = ptr;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rob_we   <= '0;
      o_rs_we    <= '0;
      o_rob_rows <= '0;
      o_rs_rows  <= '0;
      o_tail     <= '0;
      alu_ptr    <= '0;
    end else begin
      o_rob_we <= '0;
      o_rs_we  <= '0;
      if (i_flush) begin
        o_tail  <= i_flush_tail;
        alu_ptr <= '0;
      end else if (accept) begin
        o_rob_we   <= ren.lane_mask;
        o_rs_we    <= ren.lane_mask;
        o_rob_rows <= rob_nxt;
        o_rs_rows  <= rs_nxt;
        o_tail     <= next_tail;
        alu_ptr    <= alu_ptr_nxt;
      end
    end
  end

`ifdef DISPATCH_ALLOC_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cnt <= '0;
    end else if (ren.valid && !rdy && !i_flush && (o_stall_cnt != '1)) begin
      o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_alloc.sv
// Randomized scoreboard bench for dispatch_alloc against a queue-based reference model.
module tb_dispatch_alloc;
  import dispatch_alloc_pkg::*;

  localparam int W     = 2;
  localparam int DEPTH = 16;
  localparam int NALU  = 2;

  typedef rename_struct [W-1:0] ops_t;
  typedef struct {
    logic [W-1:0]               we;
    rob_row_struct [W-1:0]      rob;
    rs_row_struct  [W-1:0]      rs;
    logic [DA_ROB_IDX_W-1:0]    tail;
  } exp_t;

  logic                      i_clk = 1'b0;
  logic                      i_rst_n = 1'b0;
  logic [4:0]                rob_free = '0;
  logic [3:0]                rs_free = '0;
  logic                      flush = 1'b0;
  logic [3:0]                flush_tail = '0;
  logic [W-1:0]              rob_we;
  rob_row_struct [W-1:0]     rob_rows;
  logic [W-1:0]              rs_we;
  rs_row_struct  [W-1:0]     rs_rows;
  logic [3:0]                tail;
`ifdef DISPATCH_ALLOC_STATS_EN
  logic [31:0]               stall_cnt;
  int                        m_stall = 0;
`endif

  dispatch_if #(.WIDTH(W)) dif ();

  dispatch_alloc #(.WIDTH(W), .ROB_DEPTH(DEPTH), .RS_DEPTH(8), .NUM_ALU(NALU)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .ren          (dif.slave),
    .i_rob_free   (rob_free),
    .i_rs_free    (rs_free),
    .i_flush      (flush),
    .i_flush_tail (flush_tail),
    .o_rob_we     (rob_we),
    .o_rob_rows   (rob_rows),
    .o_rs_we      (rs_we),
    .o_rs_rows    (rs_rows),
    .o_tail       (tail)
`ifdef DISPATCH_ALLOC_STATS_EN
    ,
    .o_stall_cnt  (stall_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];
  int   m_tail    = 0;
  int   m_alu_ops = 0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic ops_t rand_ops();
    ops_t d;
    for (int i = 0; i < W; i++) begin
      d[i].alu_op       = 4'($urandom);
      d[i].mem_read     = ($urandom_range(0, 3) == 0);
      d[i].mem_write    = ($urandom_range(0, 3) == 0);
      d[i].preg_src0    = 6'($urandom);
      d[i].preg_src1    = 6'($urandom);
      d[i].preg_dst     = 6'($urandom);
      d[i].old_preg_dst = 6'($urandom);
      d[i].imm          = 16'($urandom);
    end
    return d;
  endfunction

  // Drive one cycle of stimulus; expectations go to the scoreboard queue.
  task automatic drive(input logic v, input logic [W-1:0] m, input ops_t d,
                       input int robf, input int rsf, input logic fl, input int ft);
    int   n;
    int   k;
    logic exp_ready;
    exp_t e;
    dif.valid       = v;
    dif.lane_mask   = m;
    dif.rename_data = d;
    rob_free        = 5'(robf);
    rs_free         = 4'(rsf);
    flush           = fl;
    flush_tail      = 4'(ft);
    #1;
    n = $countones(m);
    exp_ready = !fl && (robf >= n) && (rsf >= n);
    check("ready", 64'(dif.ready), 64'(exp_ready));
`ifdef DISPATCH_ALLOC_STATS_EN
    if (v && !exp_ready && !fl) m_stall++;
`endif
    if (fl) begin
      m_tail    = ft;
      m_alu_ops = 0;
    end else if (v && exp_ready && n > 0) begin
      e.we  = m;
      e.rob = '0;
      e.rs  = '0;
      k = 0;
      for (int i = 0; i < W; i++) begin
        if (m[i]) begin
          e.rob[i].valid        = 1'b1;
          e.rob[i].preg_dst     = d[i].preg_dst;
          e.rob[i].old_preg_dst = d[i].old_preg_dst;
          e.rs[i].in_use        = 1'b1;
          e.rs[i].alu_op        = d[i].alu_op;
          e.rs[i].preg_src0     = d[i].preg_src0;
          e.rs[i].preg_src1     = d[i].preg_src1;
          e.rs[i].preg_dst      = d[i].preg_dst;
          e.rs[i].imm           = d[i].imm;
          e.rs[i].rob_num       = 4'((m_tail + k) % DEPTH);
          k++;
          if (d[i].mem_read || d[i].mem_write) begin
            e.rs[i].fu = 2'(NALU);
          end else begin
            e.rs[i].fu = 2'(m_alu_ops % NALU);
            m_alu_ops++;
          end
        end
      end
      m_tail = (m_tail + n) % DEPTH;
      e.tail = 4'(m_tail);
      q.push_back(e);
    end
    @(negedge i_clk);
    check("tail", 64'(tail), 64'(m_tail));
  endtask

  // Monitor: pops an expectation whenever the DUT presents write strobes.
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #2;
      if (rob_we != '0 || rs_we != '0) begin
        if (q.size() == 0) begin
          check("unexpected_strobe", 64'({rob_we, rs_we}), 64'(0));
        end else begin
          e = q.pop_front();
          check("rob_we", 64'(rob_we), 64'(e.we));
          check("rs_we", 64'(rs_we), 64'(e.we));
          check("mon_tail", 64'(tail), 64'(e.tail));
          for (int i = 0; i < W; i++) begin
            if (e.we[i]) begin
              check($sformatf("rob_row%0d", i), 64'(rob_rows[i]), 64'(e.rob[i]));
              check($sformatf("rs_row%0d", i), 64'(rs_rows[i]), 64'(e.rs[i]));
            end
          end
        end
      end
    end
  end

  initial begin
    ops_t d;
    ops_t z;
    ops_t sw_add;
    z = '0;
    sw_add = '0;
    sw_add[0].mem_write = 1'b1;
    sw_add[0].preg_src0 = 6'd3;
    sw_add[1].alu_op    = 4'd1;
    sw_add[1].preg_dst  = 6'd7;
    dif.valid = 1'b0;
    dif.lane_mask = '0;
    dif.rename_data = '0;

    repeat (3) @(negedge i_clk);
    check("rst_rob_we", 64'(rob_we), 64'(0));
    check("rst_rs_we", 64'(rs_we), 64'(0));
    check("rst_tail", 64'(tail), 64'(0));
    check("rst_rob_rows", 64'(rob_rows), 64'(0));
    check("rst_rs_rows", 64'(rs_rows), 64'(0));
    i_rst_n = 1'b1;

    // Test 1: two ops at tail 0.
    drive(1'b1, 2'b11, rand_ops(), 16, 8, 1'b0, 0);
    // Test 2: only lane 1 at tail 5.
    drive(1'b0, 2'b00, z, 16, 8, 1'b1, 5);
    drive(1'b1, 2'b10, rand_ops(), 16, 8, 1'b0, 0);
    // Test 3: RS capacity shortfall, then enough room.
    d = rand_ops();
    drive(1'b1, 2'b11, d, 16, 1, 1'b0, 0);
    drive(1'b1, 2'b11, d, 16, 2, 1'b0, 0);
    drive(1'b1, 2'b01, d, 0, 8, 1'b0, 0);
    // Test 4: wrap from tail 15.
    drive(1'b0, 2'b00, z, 16, 8, 1'b1, 15);
    drive(1'b1, 2'b11, rand_ops(), 16, 8, 1'b0, 0);
    // Test 5: SW + ADD twice from a fresh ALU pointer.
    drive(1'b0, 2'b00, z, 16, 8, 1'b1, 0);
    drive(1'b1, 2'b11, sw_add, 16, 8, 1'b0, 0);
    drive(1'b1, 2'b11, sw_add, 16, 8, 1'b0, 0);
    // Test 6: flush beats a simultaneous bundle.
`ifdef DISPATCH_ALLOC_STATS_EN
    check("stall_pre_flush", 64'(stall_cnt), 64'(m_stall));
`endif
    drive(1'b1, 2'b11, rand_ops(), 16, 8, 1'b1, 9);
`ifdef DISPATCH_ALLOC_STATS_EN
    check("stall_post_flush", 64'(stall_cnt), 64'(m_stall));
`endif
    drive(1'b0, 2'b11, rand_ops(), 16, 8, 1'b0, 0);

    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 4) != 0), 2'($urandom), rand_ops(),
            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(2, 16),
            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(2, 8),
            ($urandom_range(0, 9) == 0), $urandom_range(0, DEPTH - 1));
    end

    // Asynchronous reset while a bundle's strobes are up.
    dif.valid = 1'b1;
    dif.lane_mask = 2'b11;
    dif.rename_data = rand_ops();
    rob_free = 5'd16;
    rs_free = 4'd8;
    flush = 1'b0;
    @(posedge i_clk);
    #1;
    check("pre_reset_we", 64'(rob_we), 64'(2'b11));
    q.delete();
    i_rst_n = 1'b0;
    #1;
    check("async_rst_rob_we", 64'(rob_we), 64'(0));
    check("async_rst_rs_we", 64'(rs_we), 64'(0));
    check("async_rst_tail", 64'(tail), 64'(0));
    dif.valid = 1'b0;
    m_tail = 0;
    m_alu_ops = 0;
`ifdef DISPATCH_ALLOC_STATS_EN
    m_stall = 0;
`endif
    @(negedge i_clk);
    i_rst_n = 1'b1;
    drive(1'b1, 2'b01, sw_add, 16, 8, 1'b0, 0);
    drive(1'b1, 2'b11, sw_add, 16, 8, 1'b0, 0);
    drive(1'b0, 2'b00, z, 16, 8, 1'b0, 0);
    drive(1'b0, 2'b00, z, 16, 8, 1'b0, 0);

`ifdef DISPATCH_ALLOC_STATS_EN
    check("stall_final", 64'(stall_cnt), 64'(m_stall));
`endif
    check("scoreboard_drain", 64'(q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
